mem_access_unit: RTL and testbench

Multi-cycle load/store initiator sitting between the CPU memory stage and the word-organised data memory. Accepts one byte/halfword/word load or store request per handshake. Handles lane selection and sign/zero extension, merges sub-word stores by read-modify-write, and rejects misaligned accesses without touching memory. Drives the memory's `wen`/`address`/`write_data` port and consumes its combinational `read_data`.

---
 rtl/mem_access_unit.sv | 95 +++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle byte/half/word load-store initiator with read-modify-write sub-word stores
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, sgn_q, sgn_d, mis_q, mis_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word_q, word_d;
  logic accept, req_mis;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data, merged;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_mis ? RESP : (req_we && req_size[1]) ? WRITE : READ;
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: if (resp_ready) state_d = IDLE;
    endcase
  end
  always_comb begin
    accept  = (state_q == IDLE) && req_valid;
    req_mis = req_size[1] ? |req_addr[1:0] : req_size[0] & req_addr[0];
    we_d    = accept ? req_we : we_q;
    sgn_d   = accept ? req_signed : sgn_q;
    mis_d   = accept ? req_mis : mis_q;
    size_d  = accept ? req_size : size_q;
    addr_d  = accept ? req_addr[ADDR_W+1:0] : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    word_d  = (state_q == READ) ? mem_read_data : word_q;
  end
  always_comb begin
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    ld_data  = size_q[1] ? word_q :
               size_q[0] ? {{16{sgn_q & half_sel[15]}}, half_sel} :
                           {{24{sgn_q & byte_sel[7]}}, byte_sel};
    merged = word_q;
    if (size_q[1]) merged = wdata_q;
    else if (size_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  always_comb begin
    req_ready      = state_q == IDLE;
    resp_valid     = state_q == RESP;
    resp_misalign  = resp_valid & mis_q;
    resp_rdata     = (resp_valid && !we_q && !mis_q) ? ld_data : '0;
    mem_wen        = state_q == WRITE;
    mem_address    = addr_q[ADDR_W+1:2];
    mem_write_data = merged;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks against a byte-addressed reference memory
module tb_mem_access_unit;
  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 << ADDR_W;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_misalign, mem_wen;
  logic [31:0] resp_rdata, mem_write_data, mem_read_data;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] bm [0:NBYTES-1];
  int vectors = 0, errors = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_wen(mem_wen), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_wen) mem[mem_address] <= mem_write_data;

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {bm[4*w+3], bm[4*w+2], bm[4*w+1], bm[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n = nbytes(sz);
    int b = int'(a % NBYTES);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(bm[(b + i) % NBYTES]) << (8 * i);
    if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int b = int'(a % NBYTES);
    for (int i = 0; i < nbytes(sz); i++) bm[(b + i) % NBYTES] = wd[8*i +: 8];
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) bm[4*w+k] = v[8*k +: 8];
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int wens,
                        output logic [31:0] rd, output logic mis);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; wens = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_wen) wens++;
      if (resp_valid) break;
    end
    rd = resp_rdata; mis = resp_misalign;
    vectors++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
    end
  endtask

  task automatic test_reset();
    int lat, wens; logic [31:0] rd; logic mis;
    #1;
    vectors++;
    if ({req_ready, resp_valid, resp_misalign, mem_wen} !== 4'b1000 || resp_rdata !== 0 ||
        mem_address !== 0 || mem_write_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld/mis/wen=%b%b%b%b rdata=%h addr=%h wdata=%h, required 1000/0/0/0",
               req_ready, resp_valid, resp_misalign, mem_wen, resp_rdata, mem_address, mem_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wen !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewrite_wen: got %b, required 1", mem_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, resp_valid, mem_wen} !== 3'b100 || mem_address !== 0 || mem_write_data !== 0) begin
      errors++;
      $display("FAIL reset_midwrite: rdy/vld/wen=%b%b%b addr=%h wdata=%h, required 100/0/0",
               req_ready, resp_valid, mem_wen, mem_address, mem_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
    vectors++;
    if (mem[8] !== ref_word(8)) begin
      errors++;
      $display("FAIL reset_no_commit: mem[8]=%h, required %h", mem[8], ref_word(8));
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, wens, rd, mis);
    vectors++;
    if (rd !== ref_load(32'h20, 2'd2, 1'b0) || lat != 2) begin
      errors++;
      $display("FAIL reset_followup_load: rdata=%h lat=%0d, required %h lat=2", rd, lat, ref_load(32'h20, 2'd2, 1'b0));
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h13, 32'h11, 32'h12, 32'h10};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80F1, 32'h80F1_7F02};
    int lat, wens; logic [31:0] rd; logic mis;
    set_word(4, 32'h80F1_7F02);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, wens, rd, mis);
      vectors++;
      if (rd !== exps[i] || lat != 2 || mis !== 1'b0 || wens != 0) begin
        errors++;
        $display("FAIL load_%0d: rdata=%h lat=%0d mis=%b wen=%0d, required %h lat=2 mis=0 wen=0",
                 i, rd, lat, mis, wens, exps[i]);
      end
    end
  endtask

  task automatic test_subword_stores();
    int lat, wens; logic [31:0] rd; logic mis;
    set_word(4, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAA, lat, wens, rd, mis);
    @(negedge clk);
    vectors++;
    if (mem[4] !== 32'h11AA_3344 || wens != 1 || lat != 3 || rd !== 0) begin
      errors++;
      $display("FAIL sb: mem=%h wen=%0d lat=%0d rdata=%h, required 11aa3344 wen=1 lat=3 rdata=0", mem[4], wens, lat, rd);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234_BEEF, lat, wens, rd, mis);
    @(negedge clk);
    vectors++;
    if (mem[4] !== 32'h11AA_BEEF || wens != 1 || lat != 3) begin
      errors++;
      $display("FAIL sh: mem=%h wen=%0d lat=%0d, required 11aabeef wen=1 lat=3", mem[4], wens, lat);
    end
    ref_store(32'h12, 2'd0, 32'hAA);
    ref_store(32'h10, 2'd1, 32'hBEEF);
  endtask

  task automatic test_misaligned();
    int lat, wens; logic [31:0] rd; logic mis;
    logic [31:0] w4 = mem[4], w5 = mem[5];
    do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, lat, wens, rd, mis);
    vectors++;
    if (mis !== 1'b1 || lat != 1 || wens != 0 || rd !== 0) begin
      errors++;
      $display("FAIL mis_lh: mis=%b lat=%0d wen=%0d rdata=%h, required 1/1/0/0", mis, lat, wens, rd);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h16, 32'hCAFE_F00D, lat, wens, rd, mis);
    @(negedge clk);
    vectors++;
    if (mis !== 1'b1 || lat != 1 || wens != 0 || mem[4] !== w4 || mem[5] !== w5) begin
      errors++;
      $display("FAIL mis_sw: mis=%b lat=%0d wen=%0d mem4=%h mem5=%h, required 1/1/0 %h %h",
               mis, lat, wens, mem[4], mem[5], w4, w5);
    end
  endtask

  task automatic test_backpressure();
    int lat, wens; logic [31:0] rd; logic mis;
    logic [31:0] exp = ref_load(32'h40, 2'd0, 1'b1);
    resp_ready = 1'b0;
    do_req(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, lat, wens, rd, mis);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: vld=%b rdata=%h rdy=%b, required 1 %h 0", i, resp_valid, resp_rdata, req_ready, exp);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%b vld=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_wrap();
    int lat, wens; logic [31:0] rd; logic mis;
    do_req(1'b1, 2'd2, 1'b0, 32'(4 << ADDR_W), 32'h5A5A_0F0F, lat, wens, rd, mis);
    @(negedge clk);
    ref_store(32'(4 << ADDR_W), 2'd2, 32'h5A5A_0F0F);
    vectors++;
    if (mem[0] !== 32'h5A5A_0F0F || wens != 1 || lat != 2) begin
      errors++;
      $display("FAIL wrap: mem0=%h wen=%0d lat=%0d, required 5a5a0f0f wen=1 lat=2", mem[0], wens, lat);
    end
  endtask

  task automatic test_random();
    int lat, wens; logic [31:0] rd; logic mis;
    for (int i = 0; i < 300; i++) begin
      logic we = 1'($urandom);
      logic [1:0] sz = 2'($urandom);
      logic sg = 1'($urandom);
      logic [31:0] a = $urandom_range(0, 63) | ($urandom_range(0, 3) << 12);
      logic [31:0] wd = $urandom;
      int n = nbytes(sz);
      logic emis = (a % n) != 0;
      int elat = emis ? 1 : (we && n < 4) ? 3 : 2;
      logic [31:0] erd = (we || emis) ? 32'h0 : ref_load(a, sz, sg);
      int ew = int'((a % NBYTES) / 4);
      do_req(we, sz, sg, a, wd, lat, wens, rd, mis);
      @(negedge clk);
      if (we && !emis) ref_store(a, sz, wd);
      vectors++;
      if (rd !== erd || mis !== emis || lat != elat || wens != ((we && !emis) ? 1 : 0) || mem[ew] !== ref_word(ew)) begin
        errors++;
        $display("FAIL random_%0d we=%b sz=%0d sg=%b a=%h: rdata=%h mis=%b lat=%0d wen=%0d mem=%h, required %h %b %0d %0d %h",
                 i, we, sz, sg, a, rd, mis, lat, wens, mem[ew], erd, emis, elat, (we && !emis) ? 1 : 0, ref_word(ew));
      end
    end
  endtask

  initial begin
    for (int w = 0; w < (1 << ADDR_W); w++) set_word(w, $urandom);
    test_reset();
    test_loads();
    test_subword_stores();
    test_misaligned();
    test_backpressure();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
